sram_arbiter: RTL and testbench



---
 rtl/sram_arbiter_if.sv | 36 +++
 rtl/sram_arbiter.sv | 199 +++++++++++++++++++
 tb/tb_sram_arbiter.sv | 317 +++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/sram_arbiter_if.sv
// sram_arbiter_if
//   Requester-side bus of the SRAM arbiter: three req/gnt ports sharing one
//   SRAM_Controller, plus the read-return signals.
//   master modport : requester side (drives req/we_n/address/write_data)
//   slave modport  : arbiter side (drives gnt/rvalid/rdata)
//   req[p], we_n[p]      per-port request and active-low write enable
//   address0/1/2         per-port 18-bit address
//   write_data0/1/2      per-port 16-bit write data
//   gnt                  one-hot combinational grant
//   rvalid[p]            per-port read-data valid
//   rdata                SRAM read data broadcast to all ports
interface sram_arbiter_if;
   logic [2:0]  req;
   logic [2:0]  we_n;
   logic [17:0] address0;
   logic [17:0] address1;
   logic [17:0] address2;
   logic [15:0] write_data0;
   logic [15:0] write_data1;
   logic [15:0] write_data2;
   logic [2:0]  gnt;
   logic [2:0]  rvalid;
   logic [15:0] rdata;

   modport master (
      output req, we_n, address0, address1, address2,
             write_data0, write_data1, write_data2,
      input  gnt, rvalid, rdata
   );

   modport slave (
      input  req, we_n, address0, address1, address2,
             write_data0, write_data1, write_data2,
      output gnt, rvalid, rdata
   );
endinterface

// File: rtl/sram_arbiter.sv
// sram_arbiter
//   Shares one SRAM_Controller port between the display fetch (port 0), the
//   colourspace-conversion datapath (port 1) and the IDCT/decode datapath
//   (port 2). Accepted accesses are registered onto the controller inputs and
//   read data is steered back through a valid/port pipeline matched to the
//   SRAM read latency. A burst cap limits how long one port keeps the memory
//   while another port is waiting.
//
//   Parameters : READ_LATENCY (2..6), MAX_BURST (1..15)
//   Ports      : Clock_50, Resetn (async, active low)
//                bus             sram_arbiter_if.slave requester bus
//                SRAM_ready      controller ready, no grants while low
//                SRAM_read_data  read data from the controller
//                SRAM_address, SRAM_write_data, SRAM_we_n  registered outputs
//   Build option: define SRAM_ARB_RR_EN for round-robin selection of a new
//   owner; otherwise selection is fixed priority 0 > 1 > 2.
module sram_arbiter #(
   parameter int READ_LATENCY = 3,
   parameter int MAX_BURST    = 8
) (
   input  logic        Clock_50,
   input  logic        Resetn,
   sram_arbiter_if.slave bus,
   input  logic        SRAM_ready,
   input  logic [15:0] SRAM_read_data,
   output logic [17:0] SRAM_address,
   output logic [15:0] SRAM_write_data,
   output logic        SRAM_we_n
);

   typedef enum logic [1:0] {
      OWN_P0   = 2'd0,
      OWN_P1   = 2'd1,
      OWN_P2   = 2'd2,
      OWN_NONE = 2'd3
   } owner_e;

   localparam logic [3:0] BURST_CAP = 4'(MAX_BURST);

   owner_e      owner_q, owner_nxt;
   logic [3:0]  burst_q, burst_nxt;
   logic [2:0]  owner_mask;
   logic [2:0]  others_req;
   logic        owner_req;
   logic [2:0]  gnt_c;
   logic [1:0]  acc_port;
   logic        accept;
   logic        acc_read;
   logic [17:0] acc_addr;
   logic [15:0] acc_wdata;
   logic        acc_we_n;

   logic [READ_LATENCY-1:0]      vld_p;
   logic [READ_LATENCY-1:0][1:0] port_p;

   function automatic logic [1:0] pick_fixed(input logic [2:0] cand);
      logic [1:0] pick;
      if (cand[0])      pick = 2'd0;
      else if (cand[1]) pick = 2'd1;
      else              pick = 2'd2;
      return pick;
   endfunction

`ifdef SRAM_ARB_RR_EN
   logic [1:0] rr_last_q, rr_last_nxt;

   // Search starts just after the last owner and wraps 2 -> 0.
   function automatic logic [1:0] pick_rr(input logic [2:0] cand, input logic [1:0] last);
      logic [1:0] p;
      logic [1:0] pick;
      logic       found;
      p     = (last >= 2'd2) ? 2'd0 : last + 2'd1;
      pick  = 2'd0;
      found = 1'b0;
      for (int i = 0; i < 3; i++) begin
         if (!found && cand[p]) begin
            pick  = p;
            found = 1'b1;
         end
         p = (p == 2'd2) ? 2'd0 : p + 2'd1;
      end
      return pick;
   endfunction
`endif

   // Owner/burst state register
   always_ff @(posedge Clock_50 or negedge Resetn) begin
      if (!Resetn) begin
         owner_q   <= OWN_NONE;
         burst_q   <= 4'd0;
`ifdef SRAM_ARB_RR_EN
         rr_last_q <= 2'd2;
`endif
      end else begin
         owner_q   <= owner_nxt;
         burst_q   <= burst_nxt;
`ifdef SRAM_ARB_RR_EN
         rr_last_q <= rr_last_nxt;
`endif
      end
   end

   // Grant decision and next owner
   always_comb begin
      owner_nxt = owner_q;
      burst_nxt = burst_q;
      gnt_c     = 3'b000;
      acc_port  = 2'd0;
`ifdef SRAM_ARB_RR_EN
      rr_last_nxt = rr_last_q;
`endif
      case (owner_q)
         OWN_P0:  owner_mask = 3'b001;
         OWN_P1:  owner_mask = 3'b010;
         OWN_P2:  owner_mask = 3'b100;
         default: owner_mask = 3'b000;
      endcase
      owner_req  = |(bus.req & owner_mask);
      others_req = bus.req & ~owner_mask;

      // With SRAM_ready low everything holds so the burst resumes afterwards.
      if (Resetn && SRAM_ready) begin
         if (bus.req == 3'b000) begin
            owner_nxt = OWN_NONE;
            burst_nxt = 4'd0;
         end else if (owner_req && ((burst_q < BURST_CAP) || (others_req == 3'b000))) begin
            gnt_c     = owner_mask;
            acc_port  = owner_q;
            burst_nxt = (burst_q == 4'hF) ? burst_q : burst_q + 4'd1;
         end else begin
            // Owner either dropped req or hit the cap with others waiting;
            // others_req is non-zero in both cases.
`ifdef SRAM_ARB_RR_EN
            acc_port    = pick_rr(others_req, rr_last_q);
            rr_last_nxt = acc_port;
`else
            acc_port = pick_fixed(others_req);
`endif
            owner_nxt = owner_e'(acc_port);
            burst_nxt = 4'd1;
            gnt_c     = 3'b001 << acc_port;
         end
      end
   end

   assign accept = |gnt_c;

   always_comb begin
      acc_addr  = bus.address0;
      acc_wdata = bus.write_data0;
      acc_we_n  = bus.we_n[0];
      case (acc_port)
         2'd1: begin
            acc_addr  = bus.address1;
            acc_wdata = bus.write_data1;
            acc_we_n  = bus.we_n[1];
         end
         2'd2: begin
            acc_addr  = bus.address2;
            acc_wdata = bus.write_data2;
            acc_we_n  = bus.we_n[2];
         end
         default: ;
      endcase
   end

   assign acc_read = accept & acc_we_n;

   // Controller-side registers; address/data hold when nothing is accepted
   always_ff @(posedge Clock_50 or negedge Resetn) begin
      if (!Resetn) begin
         SRAM_address    <= 18'd0;
         SRAM_write_data <= 16'd0;
         SRAM_we_n       <= 1'b1;
      end else if (accept) begin
         SRAM_address    <= acc_addr;
         SRAM_write_data <= acc_wdata;
         SRAM_we_n       <= acc_we_n;
      end else begin
         SRAM_we_n       <= 1'b1;
      end
   end

   // Read-return pipeline, loaded on the same edge as SRAM_address
   always_ff @(posedge Clock_50 or negedge Resetn) begin
      if (!Resetn) begin
         vld_p  <= '0;
         port_p <= '0;
      end else begin
         vld_p  <= {vld_p[READ_LATENCY-2:0], acc_read};
         port_p <= {port_p[READ_LATENCY-2:0], acc_port};
      end
   end

   assign bus.gnt    = gnt_c;
   assign bus.rvalid = vld_p[READ_LATENCY-1] ? (3'b001 << port_p[READ_LATENCY-1]) : 3'b000;
   assign bus.rdata  = SRAM_read_data;

endmodule

// File: tb/tb_sram_arbiter.sv
// tb_sram_arbiter
//   Directed-vector bench for sram_arbiter with a scoreboard. Stimulus pushes
//   per-port access queues plus the hand-ordered list of expected accepts; a
//   monitor pops expectations whenever the DUT grants, registers an access or
//   returns read data. A small SRAM model returns a function of the address
//   READ_LATENCY edges after the address is registered.
module tb_sram_arbiter;
`ifdef SRAM_ARB_RR_EN
   localparam int MB = 1;
`else
   localparam int MB = 8;
`endif
   localparam int RL = 3;

   typedef struct packed { logic we_n; logic [17:0] addr; logic [15:0] data; } acc_t;
   typedef struct packed { logic [1:0] port; logic we_n; logic [17:0] addr; logic [15:0] data; } exp_t;
   typedef struct packed { logic [1:0] port; logic [17:0] addr; int due; } rd_t;

   logic        Clock_50 = 1'b0;
   logic        Resetn = 1'b0;
   logic        SRAM_ready = 1'b1;
   logic [15:0] SRAM_read_data;
   logic [17:0] SRAM_address;
   logic [15:0] SRAM_write_data;
   logic        SRAM_we_n;

   sram_arbiter_if bus();

   sram_arbiter #(.READ_LATENCY(RL), .MAX_BURST(MB)) dut (
      .Clock_50        (Clock_50),
      .Resetn          (Resetn),
      .bus             (bus),
      .SRAM_ready      (SRAM_ready),
      .SRAM_read_data  (SRAM_read_data),
      .SRAM_address    (SRAM_address),
      .SRAM_write_data (SRAM_write_data),
      .SRAM_we_n       (SRAM_we_n)
   );

   always #10 Clock_50 = ~Clock_50;

   int   checks = 0;
   int   errors = 0;
   int   cyc = 0;
   int   acc_cnt [3];
   bit   mon_en = 1'b0;
   bit   pend_v = 1'b0;
   exp_t pend;
   logic [2:0] acc_s = 3'b000;

   acc_t pq0[$];
   acc_t pq1[$];
   acc_t pq2[$];
   exp_t exp_q[$];
   rd_t  rd_q[$];

   function automatic logic [15:0] mdata(input logic [17:0] a);
      return a[15:0] ^ {a[17:16], 14'h1A5B};
   endfunction

   // SRAM model: word for the address registered at edge n is on the bus
   // during the cycle ending at edge n+RL.
   logic [17:0] a_h0, a_h1;
   initial forever begin
      @(posedge Clock_50);
      a_h1 = a_h0;
      a_h0 = SRAM_address;
   end
   assign SRAM_read_data = mdata(a_h1);

   task automatic check(input string nm, input logic [31:0] act, input logic [31:0] req_v);
      checks++;
      if (act !== req_v) begin
         errors++;
         $display("FAIL %s actual=%0h required=%0h (cycle %0d)", nm, act, req_v, cyc);
      end
   endtask

   task automatic push_exp(input int p, input logic we, input logic [17:0] a, input logic [15:0] d);
      exp_t e;
      e.port = p[1:0];
      e.we_n = we;
      e.addr = a;
      e.data = d;
      exp_q.push_back(e);
   endtask

   task automatic issue(input int p, input logic we, input logic [17:0] a, input logic [15:0] d, input bit with_exp);
      acc_t t;
      t.we_n = we;
      t.addr = a;
      t.data = d;
      case (p)
         0: pq0.push_back(t);
         1: pq1.push_back(t);
         default: pq2.push_back(t);
      endcase
      if (with_exp) push_exp(p, we, a, d);
   endtask

   initial forever begin
      @(posedge Clock_50);
      cyc++;
   end

   // Sample accepts away from the edge
   initial forever begin
      @(negedge Clock_50);
      acc_s = bus.req & bus.gnt;
   end

   // Requester driver: retire accepted heads, then present the next head
   initial forever begin
      acc_t tmp;
      @(posedge Clock_50);
      #1;
      if (acc_s[0] && pq0.size() != 0) begin tmp = pq0.pop_front(); acc_cnt[0]++; end
      if (acc_s[1] && pq1.size() != 0) begin tmp = pq1.pop_front(); acc_cnt[1]++; end
      if (acc_s[2] && pq2.size() != 0) begin tmp = pq2.pop_front(); acc_cnt[2]++; end
      bus.req = {pq2.size() != 0, pq1.size() != 0, pq0.size() != 0};
      if (pq0.size() != 0) begin bus.we_n[0] = pq0[0].we_n; bus.address0 = pq0[0].addr; bus.write_data0 = pq0[0].data; end
      if (pq1.size() != 0) begin bus.we_n[1] = pq1[0].we_n; bus.address1 = pq1[0].addr; bus.write_data1 = pq1[0].data; end
      if (pq2.size() != 0) begin bus.we_n[2] = pq2[0].we_n; bus.address2 = pq2[0].addr; bus.write_data2 = pq2[0].data; end
   end

   // Scoreboard monitor
   initial forever begin
      exp_t e;
      rd_t  r;
      @(negedge Clock_50);
      if (Resetn && mon_en) begin
         if (pend_v) begin
            check("sram_address", SRAM_address, pend.addr);
            check("sram_we_n", SRAM_we_n, pend.we_n);
            check("sram_write_data", SRAM_write_data, pend.data);
         end else begin
            check("sram_we_n_idle", SRAM_we_n, 1'b1);
         end
         pend_v = 1'b0;

         if (bus.rvalid != 3'b000) begin
            if (rd_q.size() == 0) begin
               check("rvalid_unexpected", bus.rvalid, 3'b000);
            end else begin
               r = rd_q.pop_front();
               check("rvalid_port", bus.rvalid, 3'b001 << r.port);
               check("rdata", bus.rdata, mdata(r.addr));
               check("rvalid_latency", cyc, r.due);
            end
         end else if (rd_q.size() != 0 && rd_q[0].due <= cyc) begin
            r = rd_q.pop_front();
            check("rvalid_missing", bus.rvalid, 3'b001 << r.port);
         end

         check("gnt_when_req", |bus.gnt, SRAM_ready && (bus.req != 3'b000));
         if (bus.gnt != 3'b000) begin
            if (exp_q.size() == 0) begin
               check("gnt_unexpected", bus.gnt, 3'b000);
            end else begin
               e = exp_q.pop_front();
               check("gnt_port", bus.gnt, 3'b001 << e.port);
               pend   = e;
               pend_v = 1'b1;
               if (e.we_n) begin
                  r.port = e.port;
                  r.addr = e.addr;
                  r.due  = cyc + RL;
                  rd_q.push_back(r);
               end
            end
         end
      end
   end

   task automatic clear_cnt();
      for (int i = 0; i < 3; i++) acc_cnt[i] = 0;
   endtask

   task automatic wait_acc(input int p, input int n);
      int k = 0;
      while (acc_cnt[p] < n && k < 300) begin
         @(posedge Clock_50);
         #2;
         k++;
      end
      check("wait_acc_timeout", acc_cnt[p] >= n, 1'b1);
   endtask

   task automatic wait_drain();
      int k = 0;
      while (((pq0.size() + pq1.size() + pq2.size() + exp_q.size() + rd_q.size()) != 0 || pend_v) && k < 600) begin
         @(posedge Clock_50);
         #2;
         k++;
      end
      check("drain_timeout", k < 600, 1'b1);
      repeat (2) @(posedge Clock_50);
   endtask

   task automatic reset_pulse();
      @(posedge Clock_50);
      #3;
      Resetn = 1'b0;
      pq0.delete();
      pq1.delete();
      pq2.delete();
      exp_q.delete();
      rd_q.delete();
      pend_v  = 1'b0;
      acc_s   = 3'b000;
      bus.req = 3'b000;
      #1;
      check("rst_sram_address", SRAM_address, 18'd0);
      check("rst_sram_write_data", SRAM_write_data, 16'd0);
      check("rst_sram_we_n", SRAM_we_n, 1'b1);
      check("rst_rvalid", bus.rvalid, 3'b000);
      check("rst_gnt", bus.gnt, 3'b000);
      repeat (3) @(posedge Clock_50);
      #3;
      Resetn = 1'b1;
   endtask

   initial begin
      #200000;
      $display("FAIL watchdog expired at cycle %0d", cyc);
      $fatal(1, "watchdog");
   end

   initial begin
      bus.req = 3'b000;
      bus.we_n = 3'b111;
      bus.address0 = '0; bus.address1 = '0; bus.address2 = '0;
      bus.write_data0 = '0; bus.write_data1 = '0; bus.write_data2 = '0;
      clear_cnt();

      // Reset state
      repeat (2) @(posedge Clock_50);
      #2;
      check("init_sram_address", SRAM_address, 18'd0);
      check("init_sram_write_data", SRAM_write_data, 16'd0);
      check("init_sram_we_n", SRAM_we_n, 1'b1);
      check("init_rvalid", bus.rvalid, 3'b000);
      check("init_gnt", bus.gnt, 3'b000);
      @(posedge Clock_50);
      #3;
      Resetn = 1'b1;
      mon_en = 1'b1;
      repeat (2) @(posedge Clock_50);

      // Port 1 read burst 100..103
      clear_cnt();
      for (int i = 0; i < 4; i++) issue(1, 1'b1, 18'(100 + i), 16'h0000, 1'b1);
      wait_drain();

      // Port 2 single write, no read data returned
      issue(2, 1'b0, 18'd146944, 16'hABCD, 1'b1);
      repeat (RL + 3) begin
         @(negedge Clock_50);
         check("write_no_rvalid", bus.rvalid, 3'b000);
      end
      wait_drain();

`ifdef SRAM_ARB_RR_EN
      // Round-robin with a burst cap of 1, from reset
      reset_pulse();
      repeat (2) @(posedge Clock_50);
      for (int r = 0; r < 3; r++)
         for (int p = 0; p < 3; p++)
            issue(p, 1'b1, 18'(800 + 10 * p + r), 16'h0000, 1'b1);
      wait_drain();
`else
      // Fixed priority with burst cap: 1x8, 2x8, 0x3 (joins mid-burst), 1x4, 2x2
      clear_cnt();
      for (int i = 0; i < 12; i++) issue(1, 1'b1, 18'(300 + i), 16'h0000, 1'b0);
      for (int i = 0; i < 10; i++) issue(2, 1'b0, 18'(400 + i), 16'(16'h1000 + i), 1'b0);
      for (int i = 0; i < 8; i++)  push_exp(1, 1'b1, 18'(300 + i), 16'h0000);
      for (int i = 0; i < 8; i++)  push_exp(2, 1'b0, 18'(400 + i), 16'(16'h1000 + i));
      for (int i = 0; i < 3; i++)  push_exp(0, 1'b1, 18'(500 + i), 16'h0000);
      for (int i = 8; i < 12; i++) push_exp(1, 1'b1, 18'(300 + i), 16'h0000);
      for (int i = 8; i < 10; i++) push_exp(2, 1'b0, 18'(400 + i), 16'(16'h1000 + i));
      wait_acc(2, 3);
      for (int i = 0; i < 3; i++) issue(0, 1'b1, 18'(500 + i), 16'h0000, 1'b0);
      wait_drain();
`endif

      // SRAM_ready low for 5 cycles with 3 reads outstanding
      clear_cnt();
      for (int i = 0; i < 8; i++) issue(0, 1'b1, 18'(200 + i), 16'h0000, 1'b1);
      wait_acc(0, 3);
      SRAM_ready = 1'b0;
      repeat (5) begin
         @(negedge Clock_50);
         check("ready_low_gnt", bus.gnt, 3'b000);
      end
      @(posedge Clock_50);
      #2;
      SRAM_ready = 1'b1;
      wait_drain();
      check("ready_burst_done", acc_cnt[0], 8);

      // Asynchronous reset during a 6-read burst with reads in flight
      clear_cnt();
      for (int i = 0; i < 6; i++) issue(0, 1'b1, 18'(600 + i), 16'h0000, 1'b1);
      wait_acc(0, 4);
      reset_pulse();
      repeat (RL + 2) begin
         @(negedge Clock_50);
         check("post_reset_rvalid", bus.rvalid, 3'b000);
      end
      issue(1, 1'b1, 18'd700, 16'h0000, 1'b1);
      wait_drain();

      $display("CHECKS %0d ERRORS %0d", checks, errors);
      $finish;
   end

endmodule
